// File: rtl/vend_if.sv
// vend_if: balance/selection inputs and dispense/change outputs of the vending transaction controller
interface vend_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] balance;
  logic             sel_valid;
  logic [1:0]       sel_item;
  logic             cancel;
  logic             clear_en;
  logic             coin_lock;
  logic             dispense_valid;
  logic [1:0]       dispense_item;
  logic             change_valid;
  logic [WIDTH-1:0] change_value;
  logic             reject;
  logic             busy;
  modport master (
    output balance, sel_valid, sel_item, cancel,
    input  clear_en, coin_lock, dispense_valid, dispense_item, change_valid, change_value, reject, busy
  );
  modport slave (
    input  balance, sel_valid, sel_item, cancel,
    output clear_en, coin_lock, dispense_valid, dispense_item, change_valid, change_value, reject, busy
  );
endinterface

// File: rtl/vend_controller.sv
// vend_controller: selection/cancel transaction FSM with dispense, change and balance clear; VEND_TIMEOUT_EN adds idle auto-refund
module vend_controller #(
  parameter int WIDTH           = 4,
  parameter int PRICE0          = 5,
  parameter int PRICE1          = 7,
  parameter int PRICE2          = 3,
  parameter int PRICE3          = 0,
  parameter int DISPENSE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input logic   clk,
  input logic   reset_n,
  vend_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CHECK, DISPENSE, FINISH, REFUND} state_t;
  state_t           state;
  logic [1:0]       item;
  logic [WIDTH-1:0] price;
  logic [WIDTH-1:0] snap;
  logic [3:0]       cnt;
  logic             lock;
  logic             timeout;
  logic [WIDTH-1:0] sel_price;
  assign bus.coin_lock = lock;
  assign bus.busy      = lock;
  // price table lookup for the item being selected
  always_comb sel_price = bus.sel_item == 2'd0 ? WIDTH'(PRICE0) :
                          bus.sel_item == 2'd1 ? WIDTH'(PRICE1) :
                          bus.sel_item == 2'd2 ? WIDTH'(PRICE2) : WIDTH'(PRICE3);
`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]    idle_cnt;
  logic [WIDTH-1:0] bal_q;
  logic             counting;
  // a cycle counts toward timeout only while idle with unchanged nonzero credit and no request
  always_comb counting = state == IDLE && bus.balance != '0 && bus.balance == bal_q && !bus.sel_valid && !bus.cancel;
  always_comb timeout = counting && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
  // idle counter restarts on any credit change, request, or activity
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idle_cnt <= '0;
      bal_q    <= '0;
    end else begin
      bal_q    <= bus.balance;
      idle_cnt <= counting && !timeout ? idle_cnt + 1'b1 : '0;
    end
`else
  assign timeout = TIMEOUT_CYCLES < 0;
`endif
  // transaction sequencing; every output is registered on the transition that produces it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state              <= IDLE;
      item               <= '0;
      price              <= '0;
      snap               <= '0;
      cnt                <= '0;
      lock               <= 1'b0;
      bus.clear_en       <= 1'b0;
      bus.dispense_valid <= 1'b0;
      bus.dispense_item  <= '0;
      bus.change_valid   <= 1'b0;
      bus.change_value   <= '0;
      bus.reject         <= 1'b0;
    end else begin
      bus.clear_en     <= 1'b0;
      bus.change_valid <= 1'b0;
      bus.change_value <= '0;
      bus.reject       <= 1'b0;
      case (state)
        IDLE:
          if ((bus.cancel || timeout) && bus.balance != '0) begin
            state            <= REFUND;
            lock             <= 1'b1;
            bus.clear_en     <= 1'b1;
            bus.change_valid <= 1'b1;
            bus.change_value <= bus.balance;
          end else if (bus.sel_valid) begin
            state <= CHECK;
            lock  <= 1'b1;
            item  <= bus.sel_item;
            price <= sel_price;
          end
        CHECK: begin
          snap <= bus.balance;
          if (price == '0 || bus.balance < price) begin
            state      <= IDLE;
            lock       <= 1'b0;
            bus.reject <= 1'b1;
          end else begin
            state              <= DISPENSE;
            cnt                <= 4'(DISPENSE_CYCLES - 1);
            bus.dispense_valid <= 1'b1;
            bus.dispense_item  <= item;
          end
        end
        DISPENSE:
          if (cnt == '0) begin
            state              <= FINISH;
            bus.dispense_valid <= 1'b0;
            bus.dispense_item  <= '0;
            bus.clear_en       <= 1'b1;
            bus.change_valid   <= snap != price;
            bus.change_value   <= snap - price;
          end else cnt <= cnt - 1'b1;
        default: begin
          state <= IDLE;
          lock  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: timeline-model self-checking bench for vend_controller
module tb_vend_controller;
  localparam int N_CYC = 1024;
  localparam int D     = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   free_at = 0;
  bit       e_lock [N_CYC];
  bit       e_clr  [N_CYC];
  bit       e_dv   [N_CYC];
  bit [1:0] e_di   [N_CYC];
  bit       e_cv   [N_CYC];
  bit [3:0] e_cval [N_CYC];
  bit       e_rej  [N_CYC];
  vend_if #(.WIDTH(4)) bus ();
  vend_controller dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int price_of(input int i);
    return i == 0 ? 5 : i == 1 ? 7 : i == 2 ? 3 : 0;
  endfunction
  // expected output timeline for a request presented during cycle n
  task automatic model_apply(input int n, input bit s, input bit c, input int it, input int bal);
    int p;
    int ch;
    if (n < free_at) return;
    if (c && bal != 0) begin
      e_lock[n+1] = 1; e_clr[n+1] = 1; e_cv[n+1] = 1; e_cval[n+1] = 4'(bal);
      free_at = n + 2;
    end else if (s) begin
      p = price_of(it);
      e_lock[n+1] = 1;
      if (p == 0 || bal < p) begin
        e_rej[n+2] = 1;
        free_at = n + 2;
      end else begin
        for (int k = n + 1; k <= n + 2 + D; k++) e_lock[k] = 1;
        for (int k = n + 2; k <= n + 1 + D; k++) begin e_dv[k] = 1; e_di[k] = 2'(it); end
        ch = bal - p;
        e_clr[n+2+D] = 1; e_cv[n+2+D] = ch != 0; e_cval[n+2+D] = 4'(ch);
        free_at = n + 3 + D;
      end
    end
  endtask
  task automatic model_reset(input int from);
    for (int k = from; k < N_CYC; k++) begin
      e_lock[k] = 0; e_clr[k] = 0; e_dv[k] = 0; e_di[k] = 0; e_cv[k] = 0; e_cval[k] = 0; e_rej[k] = 0;
    end
    free_at = 0;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // every cycle: all outputs against the model timeline
  always @(negedge clk) begin
    logic [11:0] act;
    logic [11:0] exp;
    act = {bus.coin_lock, bus.busy, bus.clear_en, bus.dispense_valid, bus.dispense_item,
           bus.change_valid, bus.change_value, bus.reject};
    exp = {e_lock[cyc], e_lock[cyc], e_clr[cyc], e_dv[cyc], e_di[cyc], e_cv[cyc], e_cval[cyc], e_rej[cyc]};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL cycle %0d outputs {lock,busy,clr,dv,di,cv,cval,rej}: got %h expected %h", cyc, act, exp);
    end
  end
  task automatic go(input bit s, input bit c, input int it, input int bal);
    bus.sel_valid = s; bus.cancel = c; bus.sel_item = 2'(it); bus.balance = 4'(bal);
    model_apply(cyc, s, c, it, bal);
    @(posedge clk); #1;
    bus.sel_valid = 1'b0; bus.cancel = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  initial begin
    bus.balance = '0; bus.sel_valid = 1'b0; bus.sel_item = '0; bus.cancel = 1'b0;
    #2;
    chk("reset_lock", int'(bus.coin_lock), 0);
    chk("reset_clear", int'(bus.clear_en), 0);
    idle(3);
    reset_n = 1'b1;
    idle(2);
    go(1, 0, 0, 7);
    @(negedge clk); chk("t1_lock_after_sel", int'(bus.coin_lock), 1);
    @(posedge clk); @(negedge clk); chk("t1_dispense", int'(bus.dispense_valid), 1);
    repeat (4) @(posedge clk);
    @(negedge clk); chk("t1_clear", int'(bus.clear_en), 1); chk("t1_change", int'(bus.change_value), 2);
    @(posedge clk); @(negedge clk); chk("t1_unlock", int'(bus.coin_lock), 0);
    @(posedge clk); #1;
    idle(2);
    go(1, 0, 0, 5);
    idle(6);
    chk("t2_exact_no_change", int'(bus.change_valid), 0);
    idle(2);
    go(1, 0, 1, 3);
    @(posedge clk); @(negedge clk); chk("t3_reject", int'(bus.reject), 1);
    @(posedge clk); #1;
    idle(1);
    go(1, 0, 3, 15);
    idle(1);
    go(1, 0, 1, 9);
    idle(8);
    go(1, 1, 2, 6);
    @(negedge clk); chk("t4_refund", int'(bus.change_value), 6);
    @(posedge clk); #1;
    idle(1);
    bus.balance = '0;
    idle(1);
    go(0, 1, 0, 0);
    idle(2);
    go(1, 1, 0, 0);
    idle(8);
    go(1, 0, 2, 15);
    idle(2);
    go(1, 1, 0, 2);
    idle(8);
    go(1, 0, 0, 7);
    idle(2);
    reset_n = 1'b0;
    bus.balance = '0;
    model_reset(cyc);
    #1;
    chk("rst_async_dispense", int'(bus.dispense_valid), 0);
    chk("rst_async_lock", int'(bus.coin_lock), 0);
    idle(2);
    reset_n = 1'b1;
    idle(6);
    go(1, 0, 2, 4);
    idle(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
